// File: rtl/alu_sequencer.sv
// Issue stage in front of the 8-bit ALU: registers operands, brackets every op with NOP_OP,
// captures result/zero after SETTLE_CYCLES and returns them with the tag on a valid/ready port.
module alu_sequencer #(
    parameter logic [2:0] NOP_OP        = 3'b110,
    parameter int         SETTLE_CYCLES = 1,
    parameter int         DST_W         = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [7:0]       req_a,
    input  logic [7:0]       req_b,
    input  logic [DST_W-1:0] req_dst,
    output logic [2:0]       alu_op,
    output logic [7:0]       alu_data1,
    output logic [7:0]       alu_data2,
    input  logic [7:0]       alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic             rsp_zero,
    output logic [DST_W-1:0] rsp_dst,
    output logic             rsp_err,
    output logic [7:0]       ops_done
);

    // Both ports: a transfer happens on a rising edge where valid and ready are both high;
    // valid never waits for ready, and ready is a function of state (and rsp_ready) only.

    typedef enum logic [1:0] {IDLE, SETUP, EXEC, RESP} state_t;

    localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_nx;
    logic [2:0]       op_q;
    logic [DST_W-1:0] dst_q;
    logic [2:0]       cnt;
    logic             accept;
    logic             op_legal;

    assign accept   = req_valid & req_ready;
    assign op_legal = (req_op <= 3'b101);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_valid) state_nx = op_legal ? SETUP : RESP;
            end
            SETUP: state_nx = EXEC;
            EXEC: begin
                if (cnt == 3'd0) state_nx = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (req_valid) state_nx = op_legal ? SETUP : RESP;
                    else           state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: req_ready = 1'b1;
            RESP: begin
                rsp_valid = 1'b1;
                req_ready = rsp_ready;
            end
            default: begin
                req_ready = 1'b0;
                rsp_valid = 1'b0;
            end
        endcase
    end

    // alu_op follows the next state, so it is NOP in SETUP and always returns to NOP after EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= 3'd0;
            dst_q      <= '0;
            cnt        <= 3'd0;
            alu_op     <= NOP_OP;
            alu_data1  <= 8'd0;
            alu_data2  <= 8'd0;
            rsp_result <= 8'd0;
            rsp_zero   <= 1'b0;
            rsp_dst    <= '0;
            rsp_err    <= 1'b0;
            ops_done   <= 8'd0;
        end else begin
            alu_op <= (state_nx == EXEC) ? op_q : NOP_OP;
            if (accept) begin
                op_q  <= req_op;
                dst_q <= req_dst;
                if (op_legal) begin
                    alu_data1 <= req_a;
                    alu_data2 <= req_b;
                end else begin
                    rsp_result <= 8'd0;
                    rsp_zero   <= 1'b0;
                    rsp_dst    <= req_dst;
                    rsp_err    <= 1'b1;
                end
            end
            if (state == SETUP) begin
                cnt <= SETTLE_LOAD;
            end
            if (state == EXEC) begin
                if (cnt == 3'd0) begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_dst    <= dst_q;
                    rsp_err    <= 1'b0;
                end else begin
                    cnt <= cnt - 3'd1;
                end
            end
            if (rsp_valid && rsp_ready) begin
                ops_done <= ops_done + 8'd1;
            end
        end
    end

endmodule
